// File: rtl/decoder_queued_pkg.sv
// Shared encodings for the queued RV32I decode stage: opcodes, funct3 values,
// one-hot ALU/opcode-class bit positions and exception bit indices.
package decoder_queued_pkg;

  localparam int unsigned ALU_WIDTH       = 14;
  localparam int unsigned OPCODE_WIDTH    = 11;
  localparam int unsigned EXCEPTION_WIDTH = 4;

  // One-hot ALU operation bit positions
  localparam int unsigned ALU_ADD  = 0;
  localparam int unsigned ALU_SUB  = 1;
  localparam int unsigned ALU_SLL  = 2;
  localparam int unsigned ALU_SLT  = 3;
  localparam int unsigned ALU_SLTU = 4;
  localparam int unsigned ALU_XOR  = 5;
  localparam int unsigned ALU_SRL  = 6;
  localparam int unsigned ALU_SRA  = 7;
  localparam int unsigned ALU_OR   = 8;
  localparam int unsigned ALU_AND  = 9;
  localparam int unsigned ALU_EQ   = 10;
  localparam int unsigned ALU_NE   = 11;
  localparam int unsigned ALU_GE   = 12;
  localparam int unsigned ALU_GEU  = 13;

  // One-hot opcode class bit positions
  localparam int unsigned OPC_LUI    = 0;
  localparam int unsigned OPC_AUIPC  = 1;
  localparam int unsigned OPC_JAL    = 2;
  localparam int unsigned OPC_JALR   = 3;
  localparam int unsigned OPC_BRANCH = 4;
  localparam int unsigned OPC_LOAD   = 5;
  localparam int unsigned OPC_STORE  = 6;
  localparam int unsigned OPC_ITYPE  = 7;
  localparam int unsigned OPC_RTYPE  = 8;
  localparam int unsigned OPC_FENCE  = 9;
  localparam int unsigned OPC_SYSTEM = 10;

  localparam int unsigned EXC_ILLEGAL    = 0;
  localparam int unsigned EXC_ECALL      = 1;
  localparam int unsigned EXC_EBREAK     = 2;
  localparam int unsigned EXC_MISALIGNED = 3;

  typedef enum logic [6:0] {
    OpLoad   = 7'b0000011,
    OpFence  = 7'b0001111,
    OpImm    = 7'b0010011,
    OpAuipc  = 7'b0010111,
    OpStore  = 7'b0100011,
    OpReg    = 7'b0110011,
    OpLui    = 7'b0110111,
    OpBranch = 7'b1100011,
    OpJalr   = 7'b1100111,
    OpJal    = 7'b1101111,
    OpSystem = 7'b1110011
  } opcode_e;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
  localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

  // Width-independent control part of the decoded bundle
  typedef struct packed {
    logic                       rd_we;
    logic [2:0]                 funct3;
    logic [ALU_WIDTH-1:0]       alu;
    logic [OPCODE_WIDTH-1:0]    opcode;
    logic [EXCEPTION_WIDTH-1:0] exc;
  } ctrl_t;

endpackage

// File: rtl/decoder_fifo.sv
// Circular instruction queue between fetch and decode; holds {pc, instr} pairs.
// DEPTH must be a power of two so pointers wrap by natural overflow.
module decoder_fifo #(
  parameter int unsigned WIDTH  = 64,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PW    = $clog2(DEPTH),
  localparam int unsigned CW    = PW + 1
) (
  input  logic             d_clk,
  input  logic             d_rst,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; occupancy alone says what is valid
  always_ff @(posedge d_clk) begin
    if (push && !flush && !d_rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/decoder_queued.sv
// RV32I decode stage: a small instruction queue feeding a registered decode
// bundle, with fetch backpressure, execute stall hold and flush.
module decoder_queued
  import decoder_queued_pkg::*;
#(
  parameter int unsigned DWIDTH   = 32,
  parameter int unsigned IWIDTH   = 32,
  parameter int unsigned AWIDTH   = 5,
  parameter int unsigned PC_WIDTH = 32,
  parameter int unsigned DEPTH    = 4,
  localparam int unsigned CWIDTH  = $clog2(DEPTH) + 1
) (
  input  logic                       d_clk,
  input  logic                       d_rst,
  input  logic                       d_i_valid,
  output logic                       d_o_ready,
  input  logic [IWIDTH-1:0]          d_i_instr,
  input  logic [PC_WIDTH-1:0]        d_i_pc,
  input  logic                       d_i_stall,
  input  logic                       d_i_flush,
  output logic                       d_o_valid,
  output logic [PC_WIDTH-1:0]        d_o_pc,
  output logic [AWIDTH-1:0]          d_o_addr_rs1,
  output logic [AWIDTH-1:0]          d_o_addr_rs2,
  output logic [AWIDTH-1:0]          d_o_addr_rd,
  output logic                       d_o_rd_we,
  output logic [DWIDTH-1:0]          d_o_imm,
  output logic [2:0]                 d_o_funct3,
  output logic [ALU_WIDTH-1:0]       d_o_alu,
  output logic [OPCODE_WIDTH-1:0]    d_o_opcode,
  output logic [EXCEPTION_WIDTH-1:0] d_o_exception,
  output logic [CWIDTH-1:0]          d_o_count
);

  logic                       push, pop;
  logic [CWIDTH-1:0]          count;
  logic [PC_WIDTH+IWIDTH-1:0] head;
  logic [PC_WIDTH-1:0]        head_pc;
  logic [31:0]                instr;

  assign d_o_ready = (count != CWIDTH'(DEPTH)) && !d_rst;
  assign push      = d_i_valid && d_o_ready && !d_i_flush;
  // The output register frees up when empty or when execute takes it this cycle
  assign pop       = (count != '0) && !d_i_flush && (!d_o_valid || !d_i_stall);

  decoder_fifo #(
    .WIDTH (PC_WIDTH + IWIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .d_clk (d_clk),
    .d_rst (d_rst),
    .push  (push),
    .pop   (pop),
    .flush (d_i_flush),
    .wdata ({d_i_pc, d_i_instr}),
    .rdata (head),
    .count (count)
  );

  assign head_pc = head[PC_WIDTH+IWIDTH-1:IWIDTH];
  assign instr   = head[31:0];

  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  ctrl_t       dec;
  logic [31:0] imm32;
  logic        illegal;
  logic        writes_rd;

  always_comb begin
    dec        = '0;
    imm32      = '0;
    illegal    = 1'b0;
    writes_rd  = 1'b0;
    dec.funct3 = instr[14:12];
    if (instr[1:0] != 2'b11) begin
      illegal = 1'b1;
    end else begin
      case (instr[6:0])
        OpLui: begin
          dec.opcode[OPC_LUI] = 1'b1;
          dec.alu[ALU_ADD]    = 1'b1;
          imm32               = imm_u;
          writes_rd           = 1'b1;
        end
        OpAuipc: begin
          dec.opcode[OPC_AUIPC] = 1'b1;
          dec.alu[ALU_ADD]      = 1'b1;
          imm32                 = imm_u;
          writes_rd             = 1'b1;
        end
        OpJal: begin
          dec.opcode[OPC_JAL] = 1'b1;
          dec.alu[ALU_ADD]    = 1'b1;
          imm32               = imm_j;
          writes_rd           = 1'b1;
        end
        OpJalr: begin
          dec.opcode[OPC_JALR] = 1'b1;
          dec.alu[ALU_ADD]     = 1'b1;
          imm32                = imm_i;
          writes_rd            = 1'b1;
        end
        OpBranch: begin
          dec.opcode[OPC_BRANCH] = 1'b1;
          imm32                  = imm_b;
          case (instr[14:12])
            F3_BEQ:  dec.alu[ALU_EQ]   = 1'b1;
            F3_BNE:  dec.alu[ALU_NE]   = 1'b1;
            F3_BLT:  dec.alu[ALU_SLT]  = 1'b1;
            F3_BGE:  dec.alu[ALU_GE]   = 1'b1;
            F3_BLTU: dec.alu[ALU_SLTU] = 1'b1;
            F3_BGEU: dec.alu[ALU_GEU]  = 1'b1;
            default: illegal           = 1'b1;
          endcase
        end
        OpLoad: begin
          dec.opcode[OPC_LOAD] = 1'b1;
          dec.alu[ALU_ADD]     = 1'b1;
          imm32                = imm_i;
          writes_rd            = 1'b1;
          case (instr[14:12])
            F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU: ;
            default: illegal = 1'b1;
          endcase
        end
        OpStore: begin
          dec.opcode[OPC_STORE] = 1'b1;
          dec.alu[ALU_ADD]      = 1'b1;
          imm32                 = imm_s;
          if (instr[14] || (instr[13:12] == 2'b11)) illegal = 1'b1;
        end
        OpImm: begin
          dec.opcode[OPC_ITYPE] = 1'b1;
          imm32                 = imm_i;
          writes_rd             = 1'b1;
          case (instr[14:12])
            F3_ADD:  dec.alu[ALU_ADD]  = 1'b1;
            F3_SLL:  dec.alu[ALU_SLL]  = 1'b1;
            F3_SLT:  dec.alu[ALU_SLT]  = 1'b1;
            F3_SLTU: dec.alu[ALU_SLTU] = 1'b1;
            F3_XOR:  dec.alu[ALU_XOR]  = 1'b1;
            F3_OR:   dec.alu[ALU_OR]   = 1'b1;
            F3_AND:  dec.alu[ALU_AND]  = 1'b1;
            default: begin
              if (instr[30]) dec.alu[ALU_SRA] = 1'b1;
              else           dec.alu[ALU_SRL] = 1'b1;
            end
          endcase
        end
        OpReg: begin
          dec.opcode[OPC_RTYPE] = 1'b1;
          writes_rd             = 1'b1;
          case (instr[14:12])
            F3_ADD: begin
              if (instr[30]) dec.alu[ALU_SUB] = 1'b1;
              else           dec.alu[ALU_ADD] = 1'b1;
            end
            F3_SLL:  dec.alu[ALU_SLL]  = 1'b1;
            F3_SLT:  dec.alu[ALU_SLT]  = 1'b1;
            F3_SLTU: dec.alu[ALU_SLTU] = 1'b1;
            F3_XOR:  dec.alu[ALU_XOR]  = 1'b1;
            F3_OR:   dec.alu[ALU_OR]   = 1'b1;
            F3_AND:  dec.alu[ALU_AND]  = 1'b1;
            default: begin
              if (instr[30]) dec.alu[ALU_SRA] = 1'b1;
              else           dec.alu[ALU_SRL] = 1'b1;
            end
          endcase
        end
        OpFence: dec.opcode[OPC_FENCE] = 1'b1;
        OpSystem: begin
          dec.opcode[OPC_SYSTEM] = 1'b1;
          if (instr == INSTR_ECALL)       dec.exc[EXC_ECALL]  = 1'b1;
          else if (instr == INSTR_EBREAK) dec.exc[EXC_EBREAK] = 1'b1;
          else                            illegal             = 1'b1;
        end
        default: illegal = 1'b1;
      endcase
    end

    // Illegal words still travel down the pipe, but carry no side effects
    if (illegal) begin
      dec.alu              = '0;
      dec.opcode           = '0;
      imm32                = '0;
      writes_rd            = 1'b0;
      dec.exc[EXC_ILLEGAL] = 1'b1;
    end
    dec.rd_we               = writes_rd && (instr[11:7] != 5'd0);
    dec.exc[EXC_MISALIGNED] = (head_pc[1:0] != 2'b00);
  end

  logic                valid_q;
  logic [PC_WIDTH-1:0] pc_q;
  logic [AWIDTH-1:0]   rs1_q, rs2_q, rd_q;
  logic [DWIDTH-1:0]   imm_q;
  ctrl_t               ctrl_q;

  always_ff @(posedge d_clk) begin
    if (d_rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      imm_q   <= '0;
      ctrl_q  <= '0;
    end else if (d_i_flush) begin
      valid_q <= 1'b0;
    end else if (pop) begin
      valid_q <= 1'b1;
      pc_q    <= head_pc;
      rs1_q   <= AWIDTH'(instr[19:15]);
      rs2_q   <= AWIDTH'(instr[24:20]);
      rd_q    <= AWIDTH'(instr[11:7]);
      imm_q   <= DWIDTH'($signed(imm32));
      ctrl_q  <= dec;
    end else if (!d_i_stall) begin
      valid_q <= 1'b0;
    end
  end

  assign d_o_valid     = valid_q;
  assign d_o_pc        = pc_q;
  assign d_o_addr_rs1  = rs1_q;
  assign d_o_addr_rs2  = rs2_q;
  assign d_o_addr_rd   = rd_q;
  assign d_o_rd_we     = ctrl_q.rd_we;
  assign d_o_imm       = imm_q;
  assign d_o_funct3    = ctrl_q.funct3;
  assign d_o_alu       = ctrl_q.alu;
  assign d_o_opcode    = ctrl_q.opcode;
  assign d_o_exception = ctrl_q.exc;
  assign d_o_count     = count;

endmodule

// File: tb/tb_decoder_queued.sv
// Directed self-checking bench for decoder_queued: decode fields, immediates,
// exceptions, backpressure, flush, mid-stream reset and pointer wrap.
module tb_decoder_queued;

  logic        d_clk;
  logic        d_rst;
  logic        d_i_valid;
  logic        d_o_ready;
  logic [31:0] d_i_instr;
  logic [31:0] d_i_pc;
  logic        d_i_stall;
  logic        d_i_flush;
  logic        d_o_valid;
  logic [31:0] d_o_pc;
  logic [4:0]  d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd;
  logic        d_o_rd_we;
  logic [31:0] d_o_imm;
  logic [2:0]  d_o_funct3;
  logic [13:0] d_o_alu;
  logic [10:0] d_o_opcode;
  logic [3:0]  d_o_exception;
  logic [2:0]  d_o_count;

  int total = 0;
  int bad   = 0;

  // Expected encodings written out by hand
  localparam logic [13:0] E_ADD = 14'b00_0000_0000_0001;
  localparam logic [13:0] E_SUB = 14'b00_0000_0000_0010;
  localparam logic [13:0] E_SRA = 14'b00_0000_1000_0000;
  localparam logic [13:0] E_EQ  = 14'b00_0100_0000_0000;
  localparam logic [10:0] E_OPC_I = 11'b000_1000_0000;
  localparam logic [10:0] E_OPC_R = 11'b001_0000_0000;

  decoder_queued dut (
    .d_clk         (d_clk),
    .d_rst         (d_rst),
    .d_i_valid     (d_i_valid),
    .d_o_ready     (d_o_ready),
    .d_i_instr     (d_i_instr),
    .d_i_pc        (d_i_pc),
    .d_i_stall     (d_i_stall),
    .d_i_flush     (d_i_flush),
    .d_o_valid     (d_o_valid),
    .d_o_pc        (d_o_pc),
    .d_o_addr_rs1  (d_o_addr_rs1),
    .d_o_addr_rs2  (d_o_addr_rs2),
    .d_o_addr_rd   (d_o_addr_rd),
    .d_o_rd_we     (d_o_rd_we),
    .d_o_imm       (d_o_imm),
    .d_o_funct3    (d_o_funct3),
    .d_o_alu       (d_o_alu),
    .d_o_opcode    (d_o_opcode),
    .d_o_exception (d_o_exception),
    .d_o_count     (d_o_count)
  );

  initial d_clk = 1'b0;
  always #5 d_clk = ~d_clk;

  task automatic step();
    @(posedge d_clk);
    #1;
  endtask

  // Push one word into an empty queue and advance until it sits on the outputs
  task automatic send_one(input logic [31:0] instr, input logic [31:0] pc);
    d_i_valid = 1'b1;
    d_i_instr = instr;
    d_i_pc    = pc;
    step();
    d_i_valid = 1'b0;
    step();
  endtask

  task automatic drain();
    d_i_valid = 1'b0;
    d_i_stall = 1'b0;
    d_i_flush = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset();
    d_rst = 1'b1; d_i_valid = 1'b1; d_i_instr = 32'h003100B3; d_i_pc = 32'd4;
    step(); step();
    total++; if (d_o_count !== 3'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", d_o_count); end
    total++; if (d_o_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", d_o_valid); end
    total++; if (d_o_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", d_o_ready); end
    total++; if ({d_o_pc, d_o_imm} !== 64'd0) begin bad++; $display("FAIL reset_pc_imm got=%h/%h exp=0", d_o_pc, d_o_imm); end
    total++; if ({d_o_alu, d_o_exception, d_o_rd_we} !== 19'd0) begin bad++; $display("FAIL reset_ctrl got=%h/%h/%b exp=0", d_o_alu, d_o_exception, d_o_rd_we); end
    d_rst = 1'b0; d_i_valid = 1'b0;
    step();
    total++; if (d_o_ready !== 1'b1) begin bad++; $display("FAIL ready_after_reset got=%b exp=1", d_o_ready); end
    total++; if (d_o_count !== 3'd0) begin bad++; $display("FAIL count_after_reset got=%0d exp=0", d_o_count); end
  endtask

  task automatic test_add();
    d_i_valid = 1'b1; d_i_instr = 32'h003100B3; d_i_pc = 32'd4;
    step();
    d_i_valid = 1'b0;
    total++; if (d_o_count !== 3'd1) begin bad++; $display("FAIL add_queued_count got=%0d exp=1", d_o_count); end
    total++; if (d_o_valid !== 1'b0) begin bad++; $display("FAIL add_early_valid got=%b exp=0", d_o_valid); end
    step();
    total++; if (d_o_valid !== 1'b1) begin bad++; $display("FAIL add_valid got=%b exp=1", d_o_valid); end
    total++; if ({d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd} !== {5'd2, 5'd3, 5'd1}) begin bad++; $display("FAIL add_regs got=%0d/%0d/%0d exp=2/3/1", d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd); end
    total++; if (d_o_rd_we !== 1'b1) begin bad++; $display("FAIL add_rd_we got=%b exp=1", d_o_rd_we); end
    total++; if (d_o_alu !== E_ADD) begin bad++; $display("FAIL add_alu got=%b exp=%b", d_o_alu, E_ADD); end
    total++; if (d_o_imm !== 32'd0) begin bad++; $display("FAIL add_imm got=%h exp=0", d_o_imm); end
    total++; if (d_o_pc !== 32'd4) begin bad++; $display("FAIL add_pc got=%h exp=4", d_o_pc); end
    total++; if (d_o_opcode !== E_OPC_R) begin bad++; $display("FAIL add_opcode got=%b exp=%b", d_o_opcode, E_OPC_R); end
    step();
    total++; if (d_o_valid !== 1'b0) begin bad++; $display("FAIL add_valid_drop got=%b exp=0", d_o_valid); end
  endtask

  task automatic test_imm();
    send_one(32'hFFF40393, 32'h10); // addi x7,x8,-1
    total++; if (d_o_imm !== 32'hFFFFFFFF) begin bad++; $display("FAIL addi_imm got=%h exp=ffffffff", d_o_imm); end
    total++; if ({d_o_addr_rd, d_o_addr_rs1} !== {5'd7, 5'd8}) begin bad++; $display("FAIL addi_regs got=%0d/%0d exp=7/8", d_o_addr_rd, d_o_addr_rs1); end
    total++; if (d_o_opcode !== E_OPC_I) begin bad++; $display("FAIL addi_opcode got=%b exp=%b", d_o_opcode, E_OPC_I); end
    send_one(32'h12345937, 32'h14); // lui x18,0x12345
    total++; if (d_o_imm !== 32'h12345000) begin bad++; $display("FAIL lui_imm got=%h exp=12345000", d_o_imm); end
    total++; if ({d_o_rd_we, d_o_alu} !== {1'b1, E_ADD}) begin bad++; $display("FAIL lui_ctrl got=%b/%b exp=1/%b", d_o_rd_we, d_o_alu, E_ADD); end
    send_one(32'hFE208EE3, 32'h18); // beq x1,x2,-4
    total++; if (d_o_imm !== 32'hFFFFFFFC) begin bad++; $display("FAIL beq_imm got=%h exp=fffffffc", d_o_imm); end
    total++; if ({d_o_rd_we, d_o_alu} !== {1'b0, E_EQ}) begin bad++; $display("FAIL beq_ctrl got=%b/%b exp=0/%b", d_o_rd_we, d_o_alu, E_EQ); end
    send_one(32'h0020A423, 32'h1C); // sw x2,8(x1)
    total++; if ({d_o_imm, d_o_rd_we} !== {32'd8, 1'b0}) begin bad++; $display("FAIL sw_imm_we got=%h/%b exp=8/0", d_o_imm, d_o_rd_we); end
    send_one(32'h407302B3, 32'h20); // sub x5,x6,x7
    total++; if (d_o_alu !== E_SUB) begin bad++; $display("FAIL sub_alu got=%b exp=%b", d_o_alu, E_SUB); end
    send_one(32'h40315093, 32'h24); // srai x1,x2,3
    total++; if ({d_o_alu, d_o_imm} !== {E_SRA, 32'h403}) begin bad++; $display("FAIL srai got=%b/%h exp=%b/403", d_o_alu, d_o_imm, E_SRA); end
    drain();
  endtask

  task automatic test_exceptions();
    send_one(32'h00000000, 32'h30);
    total++; if ({d_o_valid, d_o_exception} !== {1'b1, 4'b0001}) begin bad++; $display("FAIL zero_illegal got=%b/%b exp=1/0001", d_o_valid, d_o_exception); end
    total++; if ({d_o_rd_we, d_o_alu, d_o_imm} !== 47'd0) begin bad++; $display("FAIL zero_side_effects got=%b/%b/%h exp=0", d_o_rd_we, d_o_alu, d_o_imm); end
    send_one(32'h00000073, 32'h34);
    total++; if ({d_o_exception, d_o_rd_we} !== {4'b0010, 1'b0}) begin bad++; $display("FAIL ecall got=%b/%b exp=0010/0", d_o_exception, d_o_rd_we); end
    send_one(32'h00100073, 32'h38);
    total++; if (d_o_exception !== 4'b0100) begin bad++; $display("FAIL ebreak got=%b exp=0100", d_o_exception); end
    send_one(32'hFFF40393, 32'h6);
    total++; if ({d_o_exception, d_o_rd_we} !== {4'b1000, 1'b1}) begin bad++; $display("FAIL misaligned got=%b/%b exp=1000/1", d_o_exception, d_o_rd_we); end
    send_one(32'h00002063, 32'h3C); // branch with funct3 010
    total++; if ({d_o_exception, d_o_alu} !== {4'b0001, 14'd0}) begin bad++; $display("FAIL bad_branch got=%b/%b exp=0001/0", d_o_exception, d_o_alu); end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] ins [6];
    logic [31:0] pcs [6];
    int sent, got, gap;
    logic acc;
    for (int i = 0; i < 6; i++) begin
      ins[i] = (32'(i + 1) << 7) | 32'h13;
      pcs[i] = 32'h100 + 32'(4 * i);
    end
    sent = 0; got = 0; gap = 0;
    d_i_stall = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      if (cyc == 10) begin
        total++; if (d_o_count !== 3'd4) begin bad++; $display("FAIL bp_full_count got=%0d exp=4", d_o_count); end
        total++; if (d_o_ready !== 1'b0) begin bad++; $display("FAIL bp_ready got=%b exp=0", d_o_ready); end
        total++; if (sent !== 5) begin bad++; $display("FAIL bp_accepted got=%0d exp=5", sent); end
        total++; if ({d_o_valid, d_o_pc} !== {1'b1, pcs[0]}) begin bad++; $display("FAIL bp_held got=%b/%h exp=1/%h", d_o_valid, d_o_pc, pcs[0]); end
        d_i_stall = 1'b0;
      end
      if (cyc >= 10) begin
        if (d_o_valid) begin
          if (got < 6) begin
            total++; if ({d_o_pc, d_o_addr_rd} !== {pcs[got], 5'(got + 1)}) begin bad++; $display("FAIL bp_order idx=%0d got=%h/%0d exp=%h/%0d", got, d_o_pc, d_o_addr_rd, pcs[got], got + 1); end
          end
          got++;
        end else if (got > 0 && got < 6) begin
          gap++;
        end
      end
      if (sent < 6) begin
        d_i_valid = 1'b1; d_i_instr = ins[sent]; d_i_pc = pcs[sent]; acc = d_o_ready;
      end else begin
        d_i_valid = 1'b0; acc = 1'b0;
      end
      step();
      if (acc) sent++;
    end
    total++; if (got !== 6) begin bad++; $display("FAIL bp_emerged got=%0d exp=6", got); end
    total++; if (gap !== 0) begin bad++; $display("FAIL bp_gaps got=%0d exp=0", gap); end
    drain();
  endtask

  task automatic test_flush();
    d_i_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      d_i_valid = 1'b1; d_i_instr = 32'h00100093; d_i_pc = 32'h300 + 32'(4 * i);
      step();
    end
    total++; if ({d_o_count, d_o_valid} !== {3'd3, 1'b1}) begin bad++; $display("FAIL flush_setup got=%0d/%b exp=3/1", d_o_count, d_o_valid); end
    d_i_flush = 1'b1; d_i_valid = 1'b1; d_i_pc = 32'h400;
    step();
    total++; if ({d_o_count, d_o_valid} !== {3'd0, 1'b0}) begin bad++; $display("FAIL flush_clear got=%0d/%b exp=0/0", d_o_count, d_o_valid); end
    d_i_flush = 1'b0; d_i_valid = 1'b0; d_i_stall = 1'b0;
    step(); step();
    total++; if ({d_o_count, d_o_valid} !== {3'd0, 1'b0}) begin bad++; $display("FAIL flush_dropped got=%0d/%b exp=0/0", d_o_count, d_o_valid); end
    drain();
  endtask

  task automatic test_push_pop();
    d_i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i_valid = 1'b1; d_i_instr = 32'h00100093; d_i_pc = 32'h500 + 32'(4 * i);
      step();
    end
    total++; if (d_o_count !== 3'd2) begin bad++; $display("FAIL pp_setup got=%0d exp=2", d_o_count); end
    d_i_stall = 1'b0; d_i_pc = 32'h50C;
    step();
    d_i_valid = 1'b0;
    total++; if ({d_o_count, d_o_pc} !== {3'd2, 32'h504}) begin bad++; $display("FAIL pp_same_edge got=%0d/%h exp=2/504", d_o_count, d_o_pc); end
    step();
    total++; if ({d_o_count, d_o_pc} !== {3'd1, 32'h508}) begin bad++; $display("FAIL pp_drain1 got=%0d/%h exp=1/508", d_o_count, d_o_pc); end
    step();
    total++; if ({d_o_count, d_o_valid, d_o_pc} !== {3'd0, 1'b1, 32'h50C}) begin bad++; $display("FAIL pp_drain2 got=%0d/%b/%h exp=0/1/50c", d_o_count, d_o_valid, d_o_pc); end
    drain();
  endtask

  task automatic test_mid_reset();
    d_i_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      d_i_valid = 1'b1; d_i_instr = 32'h00100093; d_i_pc = 32'h600 + 32'(4 * i);
      step();
    end
    d_rst = 1'b1;
    step();
    total++; if ({d_o_count, d_o_valid, d_o_ready} !== {3'd0, 1'b0, 1'b0}) begin bad++; $display("FAIL midrst got=%0d/%b/%b exp=0/0/0", d_o_count, d_o_valid, d_o_ready); end
    step();
    d_rst = 1'b0; d_i_valid = 1'b0; d_i_stall = 1'b0;
    step();
    total++; if ({d_o_count, d_o_valid, d_o_pc} !== {3'd0, 1'b0, 32'd0}) begin bad++; $display("FAIL midrst_after got=%0d/%b/%h exp=0/0/0", d_o_count, d_o_valid, d_o_pc); end
    drain();
  endtask

  task automatic test_wrap();
    int sent, got;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 20; cyc++) begin
      if (d_o_valid) begin
        if (got < 10) begin
          total++; if ({d_o_pc, d_o_imm} !== {32'h200 + 32'(4 * got), 32'(got)}) begin bad++; $display("FAIL wrap_order idx=%0d got=%h/%h exp=%h/%h", got, d_o_pc, d_o_imm, 32'h200 + 32'(4 * got), got); end
        end
        got++;
      end
      if (sent < 10) begin
        d_i_valid = 1'b1;
        d_i_instr = (32'(sent) << 20) | (32'(sent + 1) << 7) | 32'h13;
        d_i_pc    = 32'h200 + 32'(4 * sent);
        sent++;
      end else begin
        d_i_valid = 1'b0;
      end
      step();
    end
    total++; if (got !== 10) begin bad++; $display("FAIL wrap_count got=%0d exp=10", got); end
    drain();
  endtask

  initial begin
    d_rst = 1'b1; d_i_valid = 1'b0; d_i_instr = '0; d_i_pc = '0;
    d_i_stall = 1'b0; d_i_flush = 1'b0;
    test_reset();
    test_add();
    test_imm();
    test_exceptions();
    test_backpressure();
    test_flush();
    test_push_pop();
    test_mid_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
